// File: rtl/any1_bitfield_packer_pkg.sv
// Shared types and constants for the bitfield packer and its mask helper.
// Ports: none (package only).
// Provides the packer state enum and the word width constant.
package any1_bitfield_packer_pkg;

    localparam int BFP_WORD = 64;

    typedef enum logic {
        BFP_RUN   = 1'b0,
        BFP_DRAIN = 1'b1
    } BfPackState;

endpackage

// File: rtl/any1_bitfield_packer_if.sv
// Field-in / word-out handshake bundle for the bitfield packer.
// Ports: fld_* (valid/ready field stream), wrd_* (valid/ready packed-word stream).
// master = field producer + word consumer, slave = packer.
interface any1_bitfield_packer_if;
    import any1_bitfield_packer_pkg::*;

    logic                fld_valid_i;
    logic                fld_ready_o;
    logic [BFP_WORD-1:0] fld_data_i;
    logic [5:0]          fld_ml_i;
    logic                fld_last_i;
    logic                wrd_valid_o;
    logic                wrd_ready_i;
    logic [BFP_WORD-1:0] wrd_data_o;
    logic [6:0]          wrd_bits_o;
    logic                wrd_last_o;

    modport master (
        output fld_valid_i, fld_data_i, fld_ml_i, fld_last_i, wrd_ready_i,
        input  fld_ready_o, wrd_valid_o, wrd_data_o, wrd_bits_o, wrd_last_o
    );

    modport slave (
        input  fld_valid_i, fld_data_i, fld_ml_i, fld_last_i, wrd_ready_i,
        output fld_ready_o, wrd_valid_o, wrd_data_o, wrd_bits_o, wrd_last_o
    );

endinterface

// File: rtl/any1_bitfield_packer_bfmask.sv
// Field-length mask: bit n set when n <= ml (ml = length minus 1).
// Ports: ml (6-bit length-1) in, mask (64-bit) out. Purely combinational.
// Same helper the extract path uses to trim fields.
module any1_bitfield_packer_bfmask
    import any1_bitfield_packer_pkg::*;
(
    input  logic [5:0]          ml,
    output logic [BFP_WORD-1:0] mask
);

    always_comb begin
        mask = '0;
        for (int n = 0; n < BFP_WORD; n++) begin
            mask[n] = (6'(n) <= ml);
        end
    end

endmodule

// File: rtl/any1_bitfield_packer.sv
// Packs variable-width LSB-first fields (1..64 bits) into dense 64-bit words.
// Latency: a field that fills a word or closes a record yields a word next cycle.
// Backpressure: fld_ready drops whenever a word is pending or a record drains;
// it decodes from registers only, so there is no path from wrd_ready_i.
// Ports: clk_i, rst_ni (async active-low), bus (slave modport),
// wcnt_o emitted-word counter present only when ANY1_BFPACK_WCNT_EN is defined.
module any1_bitfield_packer
    import any1_bitfield_packer_pkg::*;
#(
    parameter int DWIDTH = BFP_WORD   // only 64 is supported
)
(
    input  logic                     clk_i,
    input  logic                     rst_ni,
    any1_bitfield_packer_if.slave    bus
`ifdef ANY1_BFPACK_WCNT_EN
    ,
    output logic [31:0]              wcnt_o
`endif
);

    localparam int ACCW = 2 * DWIDTH;

    BfPackState        st_q, st_d;
    logic [ACCW-1:0]   acc_q, acc_d;
    logic [6:0]        fill_q, fill_d;
    logic              lastp_q, lastp_d;

    logic [DWIDTH-1:0] fld_mask;
    logic              full;
    logic              fld_fire;
    logic              wrd_fire;

    any1_bitfield_packer_bfmask u_mask (
        .ml   (bus.fld_ml_i),
        .mask (fld_mask)
    );

    // fill >= 64 is exactly the top bit of the 7-bit count.
    assign full = fill_q[6];

    assign bus.fld_ready_o = (st_q == BFP_RUN) && !full;
    assign bus.wrd_valid_o = full || ((st_q == BFP_DRAIN) && (fill_q != 7'd0));
    assign bus.wrd_data_o  = acc_q[DWIDTH-1:0];
    assign bus.wrd_bits_o  = full ? 7'd64 : fill_q;
    // lastp is only set while draining, so it stands in for st==DRAIN here.
    assign bus.wrd_last_o  = lastp_q && (fill_q <= 7'd64);

    assign fld_fire = bus.fld_valid_i && bus.fld_ready_o;
    assign wrd_fire = bus.wrd_valid_o && bus.wrd_ready_i;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            st_q    <= BFP_RUN;
            acc_q   <= '0;
            fill_q  <= '0;
            lastp_q <= 1'b0;
        end else begin
            st_q    <= st_d;
            acc_q   <= acc_d;
            fill_q  <= fill_d;
            lastp_q <= lastp_d;
        end
    end

    // Field accept needs fill<64 in RUN, word handshake needs fill>=64 or
    // DRAIN, so the two branches never compete in the same cycle.
    always_comb begin
        st_d    = st_q;
        acc_d   = acc_q;
        fill_d  = fill_q;
        lastp_d = lastp_q;
        if (fld_fire) begin
            acc_d  = acc_q | ({{DWIDTH{1'b0}}, bus.fld_data_i & fld_mask} << fill_q);
            // fill_q <= 63 here, so the sum tops out at 127 and fits 7 bits.
            fill_d = fill_q + {1'b0, bus.fld_ml_i} + 7'd1;
            if (bus.fld_last_i) begin
                lastp_d = 1'b1;
                st_d    = BFP_DRAIN;
            end
        end else if (wrd_fire) begin
            if (bus.wrd_last_o) begin
                st_d    = BFP_RUN;
                lastp_d = 1'b0;
                acc_d   = '0;
                fill_d  = '0;
            end else begin
                acc_d  = acc_q >> DWIDTH;
                fill_d = full ? (fill_q - 7'd64) : 7'd0;
            end
        end
    end

`ifdef ANY1_BFPACK_WCNT_EN
    logic [31:0] wcnt_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wcnt_q <= '0;
        end else if (wrd_fire) begin
            wcnt_q <= wcnt_q + 32'd1;
        end
    end

    assign wcnt_o = wcnt_q;
`endif

endmodule
